// File: rtl/lcd_spi_fifo.sv
// lcd_spi_fifo: FIFO-buffered mode-0 SPI master with D/C tagging; define LCD_SPI_LSB_FIRST_EN for LSB-first words
module lcd_spi_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int SPI_CLK_PERIOD = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int CS_IDLE_CYCLES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          dc_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          spi_clk_o,
  output logic                          spi_dat_o,
  output logic                          spi_dc_o,
  output logic                          spi_cs_n_o
);
  localparam int HALF = SPI_CLK_PERIOD / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(HALF + CS_IDLE_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] shreg, shifted;
  logic dc_reg, cur_bit;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic push, pop, shift, half_end, gap_end, last_bit;
`ifdef LCD_SPI_LSB_FIRST_EN
  assign cur_bit = shreg[0];
  assign shifted = shreg >> 1;
`else
  assign cur_bit = shreg[DATA_WIDTH-1];
  assign shifted = shreg << 1;
`endif
  assign push = valid_i && ready_o;
  assign half_end = cnt == CW'(HALF - 1);
  assign gap_end = cnt == CW'(CS_IDLE_CYCLES - 1);
  assign last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
  assign shift = state == HIGH && half_end && !last_bit;
  assign ready_o = level_o != (AW+1)'(FIFO_DEPTH);
  assign busy_o = state != IDLE || level_o != '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = level_o != '0;
        state_nx = pop ? LOW : IDLE;
      end
      LOW: state_nx = half_end ? HIGH : LOW;
      HIGH: begin
        pop = half_end && last_bit && level_o != '0;
        state_nx = !half_end ? HIGH : (!last_bit || pop) ? LOW : HOLD;
      end
      HOLD: state_nx = half_end ? GAP : HOLD;
      GAP: state_nx = gap_end ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {dc_i, data_i};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level_o <= level_o + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // a fresh word is loaded on every pop, so the burst continues without a gap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      dc_reg <= 1'b0;
    end else begin
      cnt <= (state_nx != state || state == IDLE) ? '0 : cnt + CW'(1);
      bit_cnt <= pop ? '0 : shift ? bit_cnt + BW'(1) : bit_cnt;
      shreg <= pop ? mem[rd_ptr][DATA_WIDTH-1:0] : shift ? shifted : shreg;
      dc_reg <= pop ? mem[rd_ptr][DATA_WIDTH] : dc_reg;
    end
  end
  // pins are registered copies of the FSM view, one cycle behind the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spi_clk_o <= 1'b0;
      spi_dat_o <= 1'b0;
      spi_dc_o <= 1'b0;
      spi_cs_n_o <= 1'b1;
      done_o <= 1'b0;
    end else begin
      spi_clk_o <= state == HIGH;
      spi_dat_o <= (state == LOW || state == HIGH) && cur_bit;
      spi_dc_o <= dc_reg;
      spi_cs_n_o <= !(state == LOW || state == HIGH || state == HOLD);
      done_o <= state == HIGH && half_end && last_bit;
    end
  end
endmodule

// File: tb/tb_lcd_spi_fifo.sv
// tb_lcd_spi_fifo: directed vector bench for lcd_spi_fifo with a negedge SPI line monitor
module tb_lcd_spi_fifo;
  localparam int DW = 8, PER = 16, DEPTH = 4, GAPC = 2, HALF = PER / 2;
`ifdef LCD_SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic dc_i = 1'b0, valid_i = 1'b0;
  logic ready_o, busy_o, done_o, spi_clk_o, spi_dat_o, spi_dc_o, spi_cs_n_o;
  logic [2:0] level_o;
  int checks = 0, fails = 0;
  lcd_spi_fifo #(.DATA_WIDTH(DW), .SPI_CLK_PERIOD(PER), .FIFO_DEPTH(DEPTH), .CS_IDLE_CYCLES(GAPC)) dut (
    .clock(clock), .reset(reset), .data_i(data_i), .dc_i(dc_i), .valid_i(valid_i),
    .ready_o(ready_o), .level_o(level_o), .busy_o(busy_o), .done_o(done_o),
    .spi_clk_o(spi_clk_o), .spi_dat_o(spi_dat_o), .spi_dc_o(spi_dc_o), .spi_cs_n_o(spi_cs_n_o)
  );
  always #5 clock = ~clock;
  int cyc = 0, rises = 0, dones = 0, bursts = 0, cs_low = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, fall_cyc = 0, dc_rise_cyc = 0;
  int rise_at [1024];
  logic prev_clk = 1'b0, prev_cs = 1'b1, prev_dc = 1'b0;
  logic [63:0] bits = '0;
  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_clk <= spi_clk_o;
    prev_cs <= spi_cs_n_o;
    prev_dc <= spi_dc_o;
    if (spi_clk_o && !prev_clk) begin
      bits <= {bits[62:0], spi_dat_o};
      rise_at[rises % 1024] <= cyc;
      rises <= rises + 1;
    end
    if (!spi_clk_o && prev_clk) fall_cyc <= cyc;
    if (done_o) dones <= dones + 1;
    if (!spi_cs_n_o) cs_low <= cs_low + 1;
    if (!spi_cs_n_o && prev_cs) begin
      cs_fall_cyc <= cyc;
      bursts <= bursts + 1;
    end
    if (spi_cs_n_o && !prev_cs) cs_rise_cyc <= cyc;
    if (spi_dc_o && !prev_dc) dc_rise_cyc <= cyc;
  end
  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;
  vec_t vec [5];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
    #1;
  endtask
  task automatic push(input logic [7:0] d, input logic dc);
    data_i = d;
    dc_i = dc;
    valid_i = 1'b1;
    @(posedge clock);
    #1;
    valid_i = 1'b0;
  endtask
  task automatic wait_cs(input logic lvl, input string name);
    int n = 0;
    while (spi_cs_n_o !== lvl && n < 2000) begin
      step();
      n++;
    end
    check(name, 32'(spi_cs_n_o), 32'(lvl));
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o !== 1'b0 && n < 2000) begin
      step();
      n++;
    end
    check(name, 32'(busy_o), 32'd0);
    step();
  endtask
  function automatic logic spacing_ok(input int first, input int count);
    logic ok = 1'b1;
    for (int j = 1; j < count; j++)
      if (rise_at[(first + j) % 1024] - rise_at[(first + j - 1) % 1024] != PER) ok = 1'b0;
    return ok;
  endfunction
  initial begin
    int r0, d0, b0, c0, n;
    logic [7:0] e;
    vec[0] = '{8'hA5, 1'b1, 8'hA5, 8'hA5};
    vec[1] = '{8'h01, 1'b0, 8'h01, 8'h80};
    vec[2] = '{8'hC4, 1'b1, 8'hC4, 8'h23};
    vec[3] = '{8'h80, 1'b0, 8'h80, 8'h01};
    vec[4] = '{8'h36, 1'b1, 8'h36, 8'h6C};
    repeat (3) step();
    check("rst_clk", 32'(spi_clk_o), 32'd0);
    check("rst_dat", 32'(spi_dat_o), 32'd0);
    check("rst_dc", 32'(spi_dc_o), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    reset = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      e = LSB ? vec[i].exp_lsb : vec[i].exp_msb;
      r0 = rises;
      d0 = dones;
      push(vec[i].data, vec[i].dc);
      step();
      check("lat_e0_cs", 32'(spi_cs_n_o), 32'd1);
      step();
      check("lat_e1_cs", 32'(spi_cs_n_o), 32'd1);
      step();
      check("lat_e2_cs", 32'(spi_cs_n_o), 32'd0);
      check("lat_e2_bit", 32'(spi_dat_o), 32'(e[7]));
      check("word_dc_start", 32'(spi_dc_o), 32'(vec[i].dc));
      wait_cs(1'b1, "word_cs_release");
      check("word_rises", rises - r0, 32'd8);
      check("word_bits", 32'(bits[7:0]), 32'(e));
      check("word_dones", dones - d0, 32'd1);
      check("word_dc_end", 32'(spi_dc_o), 32'(vec[i].dc));
      check("word_first_rise", rise_at[r0 % 1024] - cs_fall_cyc, HALF);
      check("word_spacing", 32'(spacing_ok(r0, 8)), 32'd1);
      check("word_cs_after_fall", cs_rise_cyc - fall_cyc, HALF);
      wait_idle("word_idle");
    end
    push(8'h00, 1'b1);
    n = 0;
    while (done_o !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("prime_done", 32'(done_o), 32'd1);
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    push(8'h04, 1'b1);
    check("full_level", 32'(level_o), 32'd4);
    check("full_ready", 32'(ready_o), 32'd0);
    push(8'hEE, 1'b1);
    check("overflow_level", 32'(level_o), 32'd4);
    r0 = rises;
    d0 = dones;
    b0 = bursts;
    wait_cs(1'b1, "burst4_gap");
    wait_cs(1'b0, "burst4_start");
    wait_cs(1'b1, "burst4_end");
    check("burst4_rises", rises - r0, 32'd32);
    check("burst4_bits", bits[31:0], LSB ? 32'h8040C020 : 32'h01020304);
    check("burst4_dones", dones - d0, 32'd4);
    check("burst4_bursts", bursts - b0, 32'd1);
    check("burst4_span", fall_cyc - cs_fall_cyc, 32'd512);
    check("burst4_spacing", 32'(spacing_ok(r0, 32)), 32'd1);
    wait_idle("burst4_idle");
    check("burst4_level", 32'(level_o), 32'd0);
    r0 = rises;
    d0 = dones;
    b0 = bursts;
    push(8'h2A, 1'b0);
    push(8'h11, 1'b1);
    wait_cs(1'b0, "dc_start");
    check("dc_first_word", 32'(spi_dc_o), 32'd0);
    wait_cs(1'b1, "dc_end");
    check("dc_rises", rises - r0, 32'd16);
    check("dc_bits", 32'(bits[15:0]), LSB ? 32'h5488 : 32'h2A11);
    check("dc_bursts", bursts - b0, 32'd1);
    check("dc_dones", dones - d0, 32'd2);
    check("dc_switch_cycle", dc_rise_cyc - cs_fall_cyc, 32'd128);
    check("dc_second_word", 32'(spi_dc_o), 32'd1);
    wait_idle("dc_idle");
    r0 = rises;
    push(8'hFF, 1'b1);
    push(8'h55, 1'b0);
    push(8'h66, 1'b1);
    n = 0;
    while (rises - r0 < 3 && n < 400) begin
      step();
      n++;
    end
    check("rst_mid_rises", rises - r0, 32'd3);
    check("rst_mid_queued", 32'(level_o), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_cs", 32'(spi_cs_n_o), 32'd1);
    check("rst_mid_clk", 32'(spi_clk_o), 32'd0);
    check("rst_mid_level", 32'(level_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_dat", 32'(spi_dat_o), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    r0 = rises;
    c0 = cs_low;
    repeat (300) step();
    check("rst_after_rises", rises - r0, 32'd0);
    check("rst_after_cs", cs_low - c0, 32'd0);
    check("rst_after_level", 32'(level_o), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
